// File: rtl/harmonic_sequencer.sv
// Per-voice additive-synthesis sequencer: walks harmonics through a registered sine LUT into the MAC.
// Optional HARMONIC_ODD_ONLY_EN build adds odd_only to issue only odd harmonics.
module harmonic_sequencer #(
  parameter int DIVISOR_BITS  = 7,
  parameter int LUT_BITS      = 10,
  parameter int MAX_HARMONICS = 63
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      sample_tick,
  input  logic [31:0]               phase_inc,
  input  logic [5:0]                harmonic_count,
  input  logic [DIVISOR_BITS-1:0]   start_level,
  input  logic [DIVISOR_BITS-1:0]   decay_step,
`ifdef HARMONIC_ODD_ONLY_EN
  input  logic                      odd_only,
`endif
  output logic [LUT_BITS-1:0]       lut_addr,
  input  logic signed [15:0]        lut_data,
  output logic                      frac_start,
  output logic                      frac_clear,
  output logic [DIVISOR_BITS-1:0]   frac_multiple,
  output logic signed [15:0]        frac_in,
  input  logic                      frac_done,
  input  logic [31:0]               frac_accumulator,
  output logic [31:0]               sample_out,
  output logic                      sample_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic [2:0]                state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_LUT_WAIT  = 3'd3;
  localparam logic [2:0] S_START     = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_OUTPUT    = 3'd7;

  // MAC handshake: frac_start is a one-cycle request; frac_done drops the cycle after
  // the request and returns high once frac_accumulator holds the updated sum.
  logic [2:0]              state;
  logic [31:0]             phase_base;
  logic [31:0]             harm_phase;
  logic [31:0]             harm_step;
  logic [6:0]              h;
  logic [6:0]              count_q;
  logic [DIVISOR_BITS-1:0] level;
  logic [DIVISOR_BITS-1:0] decay_q;
  logic                    odd_q;
  logic                    odd_sel;
  logic [6:0]              count_clamped;
  logic [6:0]              h_inc;
  logic [DIVISOR_BITS-1:0] next_level;
  logic                    last_harm;

`ifdef HARMONIC_ODD_ONLY_EN
  assign odd_sel = odd_only;
`else
  assign odd_sel = 1'b0;
`endif

  assign count_clamped = ({1'b0, harmonic_count} > 7'(MAX_HARMONICS)) ?
                         7'(MAX_HARMONICS) : {1'b0, harmonic_count};
  assign h_inc      = odd_q ? 7'd2 : 7'd1;
  assign next_level = (level > decay_q) ? level - decay_q : '0;
  assign last_harm  = (h + h_inc) > count_q;

  assign lut_addr   = harm_phase[31:32-LUT_BITS];
  assign frac_start = (state == S_START);
  assign frac_clear = (state == S_CLEAR);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      phase_base    <= '0;
      harm_phase    <= '0;
      harm_step     <= '0;
      h             <= '0;
      count_q       <= '0;
      level         <= '0;
      decay_q       <= '0;
      odd_q         <= 1'b0;
      frac_multiple <= '0;
      frac_in       <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= sample_tick && (state != S_IDLE);
      // Pitch tracking continues through overruns so dropped samples do not detune the voice.
      if (sample_tick) phase_base <= phase_base + phase_inc;

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            if (count_clamped == 7'd0 || start_level == '0) begin
              sample_out   <= '0;
              sample_valid <= 1'b1;
            end else begin
              count_q <= count_clamped;
              level   <= start_level;
              decay_q <= decay_step;
              odd_q   <= odd_sel;
              state   <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          // Step is frozen here so a mid-sequence tick cannot change this sample's pitch.
          harm_phase <= phase_base;
          harm_step  <= odd_q ? {phase_base[30:0], 1'b0} : phase_base;
          h          <= 7'd1;
          state      <= S_ADDR;
        end
        S_ADDR:     state <= S_LUT_WAIT;
        S_LUT_WAIT: begin
          frac_in       <= lut_data;
          frac_multiple <= level;
          state         <= S_START;
        end
        S_START:    state <= S_ACK;
        S_ACK:      state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (frac_done) begin
            if (last_harm || next_level == '0) begin
              sample_out   <= frac_accumulator;
              sample_valid <= 1'b1;
              state        <= S_OUTPUT;
            end else begin
              h          <= h + h_inc;
              harm_phase <= harm_phase + harm_step;
              level      <= next_level;
              state      <= S_ADDR;
            end
          end
        end
        S_OUTPUT:   state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

endmodule
